// File: rtl/reg_slice_pkg.sv
// Shared types for the valid/ready register slices.
package reg_slice_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_e;

    // Beats held by the full slice in a given state.
    function automatic logic [OCC_W-1:0] state_occ(input slice_state_e s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/reg_slice_backward.sv
// Valid/ready slice that always drives s_rdy from a flop; REG_OUT=1 also
// registers the valid/payload path for a full two-entry slice.
module reg_slice_backward
    import reg_slice_pkg::*;
#(
    parameter int unsigned PLD_WIDTH = 32,
    parameter bit          REG_OUT   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [PLD_WIDTH-1:0] s_pld,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [PLD_WIDTH-1:0] m_pld,
    output logic [OCC_W-1:0]     occ
);

    logic                 s_rdy_r;
    logic                 s_rdy_nxt;
    logic                 push;
    logic                 skid_vld;
    logic                 skid_set;
    logic                 skid_clr;
    logic [PLD_WIDTH-1:0] skid_pld;

    assign s_rdy = s_rdy_r;
    assign push  = s_vld && s_rdy_r;

    // Ready flop; both modes compute its next value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rdy_r <= 1'b0;
        end else begin
            s_rdy_r <= s_rdy_nxt;
        end
    end

    // Skid register catches the beat accepted while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_vld <= 1'b0;
            skid_pld <= '0;
        end else if (skid_set) begin
            skid_vld <= 1'b1;
            skid_pld <= s_pld;
        end else if (skid_clr) begin
            skid_vld <= 1'b0;
        end
    end

    generate
        if (!REG_OUT) begin : g_pass
            // PASS when the skid is empty, SKID while it holds a beat
            always_comb begin
                skid_set  = 1'b0;
                skid_clr  = 1'b0;
                s_rdy_nxt = s_rdy_r;
                if (skid_vld) begin
                    if (m_rdy) begin
                        skid_clr  = 1'b1;
                        s_rdy_nxt = 1'b1;
                    end
                end else begin
                    s_rdy_nxt = 1'b1;
                    if (push && !m_rdy) begin
                        skid_set  = 1'b1;
                        s_rdy_nxt = 1'b0;
                    end
                end
            end

            assign m_vld = skid_vld || push;
            assign m_pld = skid_vld ? skid_pld : s_pld;
            assign occ   = OCC_W'(skid_vld);
        end else begin : g_full
            slice_state_e         state;
            slice_state_e         state_nxt;
            logic                 pop;
            logic                 out_load;
            logic                 out_vld;
            logic [PLD_WIDTH-1:0] out_pld;
            logic [OCC_W-1:0]     occ_r;

            assign pop = out_vld && m_rdy;

            always_comb begin
                state_nxt = state;
                out_load  = 1'b0;
                skid_set  = 1'b0;
                skid_clr  = 1'b0;
                case (state)
                    EMPTY: begin
                        if (push) begin
                            state_nxt = BUSY;
                            out_load  = 1'b1;
                        end
                    end
                    BUSY: begin
                        if (push && pop) begin
                            out_load = 1'b1;
                        end else if (push) begin
                            state_nxt = FULL;
                            skid_set  = 1'b1;
                        end else if (pop) begin
                            state_nxt = EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            state_nxt = BUSY;
                            out_load  = 1'b1;
                            skid_clr  = 1'b1;
                        end
                    end
                    default: state_nxt = EMPTY;
                endcase
                s_rdy_nxt = (state_nxt != FULL);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state   <= EMPTY;
                    out_vld <= 1'b0;
                    out_pld <= '0;
                    occ_r   <= '0;
                end else begin
                    state   <= state_nxt;
                    out_vld <= (state_nxt != EMPTY);
                    occ_r   <= state_occ(state_nxt);
                    // A held skid beat is always older than the upstream one
                    if (out_load) begin
                        out_pld <= skid_vld ? skid_pld : s_pld;
                    end
                end
            end

            assign m_vld = out_vld;
            assign m_pld = out_pld;
            assign occ   = occ_r;
        end
    endgenerate

    // Downstream must see a stalled beat unchanged until it is taken
    property p_stall_hold;
        @(posedge clk) disable iff (rst)
            (m_vld && !m_rdy) |=> (m_vld && $stable(m_pld));
    endproperty

    a_stall_hold: assert property (p_stall_hold)
        else $error("m_vld/m_pld changed while stalled");

endmodule

// File: tb/tb_reg_slice_backward.sv
// Drives a backward-only and a full slice side by side and checks them
// against vector tables, directed corner sequences and a queue scoreboard.
module tb_reg_slice_backward;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         s_vld [2];
    logic         s_rdy [2];
    logic [W-1:0] s_pld [2];
    logic         m_vld [2];
    logic         m_rdy [2];
    logic [W-1:0] m_pld [2];
    logic [1:0]   occ   [2];

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q   [2][$];
    logic [W-1:0] out_log [2][$];
    logic         held    [2];
    logic [W-1:0] held_pld[2];
    logic         acc     [2];

    typedef struct {
        logic         s_vld;
        logic [W-1:0] s_pld;
        logic         m_rdy;
        logic         e0_vld;
        logic [W-1:0] e0_pld;
        logic         e1_vld;
        logic [W-1:0] e1_pld;
    } vec_t;

    vec_t tbl [18];

    reg_slice_backward #(.PLD_WIDTH(W), .REG_OUT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .s_vld(s_vld[0]), .s_rdy(s_rdy[0]), .s_pld(s_pld[0]),
        .m_vld(m_vld[0]), .m_rdy(m_rdy[0]), .m_pld(m_pld[0]),
        .occ(occ[0])
    );

    reg_slice_backward #(.PLD_WIDTH(W), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .s_vld(s_vld[1]), .s_rdy(s_rdy[1]), .s_pld(s_pld[1]),
        .m_vld(m_vld[1]), .m_rdy(m_rdy[1]), .m_pld(m_pld[1]),
        .occ(occ[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Settle, score the handshakes about to fire, then advance one cycle
    task automatic cycle();
        #1;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                exp_q[m].delete();
                held[m] = 1'b0;
                acc[m]  = 1'b0;
            end else begin
                if (held[m]) begin
                    chkb($sformatf("m%0d hold_vld", m), m_vld[m], 1'b1);
                    chk($sformatf("m%0d hold_pld", m), m_pld[m], held_pld[m]);
                end
                acc[m] = s_vld[m] && s_rdy[m];
                if (acc[m]) exp_q[m].push_back(s_pld[m]);
                if (m_vld[m] && m_rdy[m]) begin
                    out_log[m].push_back(m_pld[m]);
                    if (exp_q[m].size() == 0) begin
                        n_total++;
                        $display("FAIL m%0d sb_order: got %0h, want no output (nothing pending)", m, m_pld[m]);
                    end else begin
                        chk($sformatf("m%0d sb_order", m), m_pld[m], exp_q[m].pop_front());
                    end
                end
                held[m]     = m_vld[m] && !m_rdy[m];
                held_pld[m] = m_pld[m];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int m);
        s_vld[m] = 1'b0;
        s_pld[m] = '0;
        m_rdy[m] = 1'b1;
    endtask

    initial begin
        int thr;
        int pops [2];
        int acc_n[2];

        for (int i = 0; i < 18; i++) begin
            tbl[i].s_vld  = (i < 16);
            tbl[i].s_pld  = (i < 16) ? W'(i + 1) : '0;
            tbl[i].m_rdy  = 1'b1;
            tbl[i].e0_vld = (i < 16);
            tbl[i].e0_pld = W'(i + 1);
            tbl[i].e1_vld = (i >= 1) && (i <= 16);
            tbl[i].e1_pld = W'(i);
        end

        // Reset with s_vld high: nothing may leak out
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            s_vld[m] = 1'b1; s_pld[m] = 32'h1234; m_rdy[m] = 1'b1;
            held[m] = 1'b0; acc[m] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            for (int m = 0; m < 2; m++) begin
                chkb($sformatf("m%0d rst_s_rdy", m), s_rdy[m], 1'b0);
                chkb($sformatf("m%0d rst_m_vld", m), m_vld[m], 1'b0);
                chki($sformatf("m%0d rst_occ", m), int'(occ[m]), 0);
            end
            cycle();
        end
        rst = 1'b0;
        idle(0); idle(1);
        #1;
        for (int m = 0; m < 2; m++) chkb($sformatf("m%0d rel_s_rdy_low", m), s_rdy[m], 1'b0);
        cycle();
        #1;
        for (int m = 0; m < 2; m++) chkb($sformatf("m%0d rel_s_rdy_high", m), s_rdy[m], 1'b1);

        // Full-rate stream 1..16 from the vector table
        out_log[0].delete(); out_log[1].delete();
        for (int i = 0; i < 18; i++) begin
            for (int m = 0; m < 2; m++) begin
                s_vld[m] = tbl[i].s_vld;
                s_pld[m] = tbl[i].s_pld;
                m_rdy[m] = tbl[i].m_rdy;
            end
            #1;
            if (i < 16) begin
                chkb($sformatf("m0 stream_s_rdy[%0d]", i), s_rdy[0], 1'b1);
                chkb($sformatf("m1 stream_s_rdy[%0d]", i), s_rdy[1], 1'b1);
            end
            chkb($sformatf("m0 stream_vld[%0d]", i), m_vld[0], tbl[i].e0_vld);
            if (tbl[i].e0_vld) chk($sformatf("m0 stream_pld[%0d]", i), m_pld[0], tbl[i].e0_pld);
            chkb($sformatf("m1 stream_vld[%0d]", i), m_vld[1], tbl[i].e1_vld);
            if (tbl[i].e1_vld) chk($sformatf("m1 stream_pld[%0d]", i), m_pld[1], tbl[i].e1_pld);
            cycle();
        end
        chki("m0 stream_count", out_log[0].size(), 16);
        chki("m1 stream_count", out_log[1].size(), 16);

        // Full slice stall capture: A and B held, C waits upstream
        idle(0);
        out_log[1].delete();
        s_vld[1] = 1'b1; m_rdy[1] = 1'b0;
        s_pld[1] = 32'hA; cycle();
        s_pld[1] = 32'hB; cycle();
        s_pld[1] = 32'hC;
        for (int c = 0; c < 2; c++) begin
            #1;
            chkb("m1 stall_s_rdy", s_rdy[1], 1'b0);
            chki("m1 stall_occ", int'(occ[1]), 2);
            chkb("m1 stall_m_vld", m_vld[1], 1'b1);
            chk("m1 stall_m_pld", m_pld[1], 32'hA);
            cycle();
        end
        m_rdy[1] = 1'b1;
        cycle();
        cycle();
        s_vld[1] = 1'b0;
        cycle(); cycle();
        chki("m1 stall_count", out_log[1].size(), 3);
        chk("m1 stall_order0", out_log[1][0], 32'hA);
        chk("m1 stall_order1", out_log[1][1], 32'hB);
        chk("m1 stall_order2", out_log[1][2], 32'hC);

        // Backward-only slice skid capture and drain
        idle(1);
        out_log[0].delete();
        s_vld[0] = 1'b1; s_pld[0] = 32'h55; m_rdy[0] = 1'b0;
        #1;
        chkb("m0 skid_pass_vld", m_vld[0], 1'b1);
        chk("m0 skid_pass_pld", m_pld[0], 32'h55);
        cycle();
        s_vld[0] = 1'b0; s_pld[0] = '0;
        #1;
        chkb("m0 skid_s_rdy", s_rdy[0], 1'b0);
        chkb("m0 skid_m_vld", m_vld[0], 1'b1);
        chk("m0 skid_m_pld", m_pld[0], 32'h55);
        chki("m0 skid_occ", int'(occ[0]), 1);
        m_rdy[0] = 1'b1;
        cycle();
        #1;
        chkb("m0 drain_s_rdy", s_rdy[0], 1'b1);
        chki("m0 drain_occ", int'(occ[0]), 0);
        chki("m0 skid_count", out_log[0].size(), 1);

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            thr = 1 + (c / 2500);
            for (int m = 0; m < 2; m++) begin
                if (!s_vld[m] || acc[m]) begin
                    s_vld[m] = ($urandom_range(0, 3) != 0);
                    s_pld[m] = $urandom;
                end
                m_rdy[m] = ($urandom_range(0, 4) < thr);
            end
            cycle();
        end
        idle(0); idle(1);
        for (int c = 0; c < 4; c++) cycle();
        for (int m = 0; m < 2; m++) begin
            chki($sformatf("m%0d rand_drain", m), exp_q[m].size(), 0);
            chki($sformatf("m%0d rand_occ", m), int'(occ[m]), 0);
        end

        // m_rdy toggling with a saturating source
        for (int m = 0; m < 2; m++) begin
            pops[m] = out_log[m].size();
            acc_n[m] = 0;
            s_vld[m] = 1'b1;
            s_pld[m] = $urandom;
        end
        for (int c = 0; c < 100; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (acc[m]) s_pld[m] = $urandom;
                m_rdy[m] = (c % 2 == 1);
            end
            cycle();
            for (int m = 0; m < 2; m++) if (acc[m]) acc_n[m]++;
        end
        for (int m = 0; m < 2; m++) begin
            n_total++;
            if (out_log[m].size() - pops[m] >= 45 && acc_n[m] >= 45) n_pass++;
            else $display("FAIL m%0d toggle_rate: got %0d out / %0d in, want >= 45 each",
                          m, out_log[m].size() - pops[m], acc_n[m]);
        end

        // Reset while holding beats
        for (int m = 0; m < 2; m++) begin
            s_vld[m] = 1'b1; m_rdy[m] = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            for (int m = 0; m < 2; m++) s_pld[m] = W'(c + 1);
            cycle();
        end
        #1;
        chki("m0 pre_rst_occ", int'(occ[0]), 1);
        chki("m1 pre_rst_occ", int'(occ[1]), 2);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chki($sformatf("m%0d midrst_occ", m), int'(occ[m]), 0);
            chkb($sformatf("m%0d midrst_m_vld", m), m_vld[m], 1'b0);
            chkb($sformatf("m%0d midrst_s_rdy", m), s_rdy[m], 1'b0);
        end
        cycle(); cycle();
        out_log[0].delete(); out_log[1].delete();
        rst = 1'b0;
        idle(0); idle(1);
        cycle(); cycle();
        for (int m = 0; m < 2; m++) begin
            chki($sformatf("m%0d post_rst_quiet", m), out_log[m].size(), 0);
            s_vld[m] = 1'b1; s_pld[m] = 32'hDEAD;
        end
        cycle();
        idle(0); idle(1);
        cycle(); cycle();
        for (int m = 0; m < 2; m++) begin
            chki($sformatf("m%0d post_rst_count", m), out_log[m].size(), 1);
            chk($sformatf("m%0d post_rst_first", m), out_log[m][0], 32'hDEAD);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_slice_backward.md
Name: reg_slice_backward

Overview:
- Ready-path pipeline slice for valid/ready streams; sits on long or high-fanout links where the m_rdy to s_rdy combinational path must be cut.
- s_rdy always comes straight from a flop; a one-entry skid register absorbs the beat in flight when downstream stalls.
- Optional output register (REG_OUT=1) also cuts the valid/payload path, giving a full two-entry slice at one beat per cycle.

Parameters:
- PLD_WIDTH, 32, payload width in bits.
- REG_OUT, 0, 0 = backward-only slice (m_vld/m_pld combinational from the skid or s_*); 1 = full slice (m_vld/m_pld registered).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- s_vld  input  1  upstream valid.
- s_rdy  output  1  upstream ready; flop output only.
- s_pld  input  PLD_WIDTH  upstream payload.
- m_vld  output  1  downstream valid.
- m_rdy  input  1  downstream ready.
- m_pld  output  PLD_WIDTH  downstream payload.
- occ  output  2  beats held in the slice (0..2); 0..1 when REG_OUT=0.

Behaviour:
- Transfer occurs on a rising clk edge when vld && rdy on that side. Payload is never dropped, duplicated or reordered.
- Reset (rst high, async):
  - s_rdy=0, skid_vld=0, out_vld=0, payload regs=0, occ=0, state=EMPTY.
  - s_rdy rises to 1 on the first clk edge after rst falls.
  - REG_OUT=0: during reset m_vld=0 (m_vld gated by the s_rdy flop).
- REG_OUT=0, skid empty (PASS):
  - m_vld = s_vld && s_rdy; m_pld = s_pld; latency 0.
  - If s_vld && s_rdy && !m_rdy: skid_pld<=s_pld, skid_vld<=1, s_rdy<=0.
- REG_OUT=0, skid full (SKID):
  - m_vld=1, m_pld=skid_pld, s_rdy=0.
  - On m_rdy: skid_vld<=0, s_rdy<=1 next cycle. No upstream beat is accepted in the draining cycle.
- REG_OUT=1 state machine; out_vld drives m_vld, out_pld drives m_pld, s_rdy_r = (next_state != FULL):
  - EMPTY:
    - s_vld && s_rdy -> BUSY, out_pld<=s_pld.
  - BUSY:
    - push && pop -> BUSY, out_pld<=s_pld.
    - push && !pop -> FULL, skid_pld<=s_pld, s_rdy<=0.
    - !push && pop -> EMPTY.
    - Otherwise hold.
  - FULL:
    - pop -> BUSY, out_pld<=skid_pld, s_rdy<=1.
    - s_rdy=0, so no push is possible.
  - Latency 1 cycle. Sustained throughput 1 beat/cycle with m_rdy held high.
- Payload stability: m_pld and m_vld must stay stable while m_vld && !m_rdy. This is checked by an assertion, in both modes.
- occ:
  - REG_OUT=1: registered, equal to EMPTY=0, BUSY=1, FULL=2.
  - REG_OUT=0: occ = skid_vld.
- m_rdy toggling every cycle must not stall an otherwise full-rate source by more than one cycle per stall event.
- rst asserted mid-traffic: all held beats are discarded immediately and s_rdy drops asynchronously. No beat is emitted until a new push after reset.

Decomposition:
- Shared package reg_slice_pkg:
  - enum slice_state_e {EMPTY, BUSY, FULL}, 2 bits.
  - localparam OCC_W=2.
- No sub-module. One module; generate-if on REG_OUT selects the PASS/SKID datapath or the three-state FSM. Skid register logic is shared between the two modes.

Test Plan:
- Reset then idle, both modes: rst high for 3 cycles -> s_rdy=0, m_vld=0, occ=0. One cycle after release, s_rdy=1.
- Streaming 0x1..0x10 with m_rdy=1:
  - REG_OUT=0 -> each beat appears on m_pld in the same cycle.
  - REG_OUT=1 -> each beat appears one cycle later.
  - Both modes: 16 beats in 16 cycles.
- Stall capture, REG_OUT=1: push 0xA, 0xB, 0xC back-to-back with m_rdy=0 -> 0xA, 0xB held, s_rdy=0, occ=2, 0xC held upstream. Release m_rdy -> output order 0xA, 0xB, 0xC.
- Skid, REG_OUT=0: push 0x55 with m_rdy=0 -> next cycle s_rdy=0, m_pld=0x55, occ=1. Raise m_rdy -> 0x55 accepted, s_rdy=1 the following cycle.
- Random s_vld/m_rdy for 10k cycles, both modes, scoreboard compare -> zero loss/duplication, stability assertion never fires.
- Reset mid-operation with occ=2 -> occ=0 and m_vld=0 immediately. The first post-reset beat 0xDEAD is the first output seen.
